// File: rtl/issue_queue_integer_pkg.sv
// Shared core types for the integer issue queue.
// Entry layout, operand/tag widths and the CDB wakeup helper.
package issue_queue_integer_pkg;

  localparam int IQ_DATA_W = 32;
  localparam int IQ_TAG_W  = 6;
  localparam int IQ_OPC_W  = 5;

  typedef logic [IQ_OPC_W-1:0]  opc_t;
  typedef logic [IQ_TAG_W-1:0]  tag_t;
  typedef logic [IQ_DATA_W-1:0] data_t;

  typedef struct packed {
    opc_t  opcode;
    data_t rs1_data;
    tag_t  rs1_tag;
    logic  rs1_rdy;
    data_t rs2_data;
    tag_t  rs2_tag;
    logic  rs2_rdy;
    tag_t  rd_tag;
  } iq_entry_t;

  // Capture a broadcast into any still-waiting operand with a matching tag.
  function automatic iq_entry_t wake(
    input iq_entry_t e,
    input tag_t      tag,
    input data_t     data
  );
    iq_entry_t r;
    r = e;
    if (!e.rs1_rdy && e.rs1_tag == tag) begin
      r.rs1_rdy  = 1'b1;
      r.rs1_data = data;
    end
    if (!e.rs2_rdy && e.rs2_tag == tag) begin
      r.rs2_rdy  = 1'b1;
      r.rs2_data = data;
    end
    return r;
  endfunction

  function automatic logic both_rdy(input iq_entry_t e);
    return e.rs1_rdy & e.rs2_rdy;
  endfunction

endpackage

// File: rtl/issue_queue_integer_select.sv
// Oldest-ready picker for the integer issue queue.
// Lowest set bit of the ready vector wins.
module issue_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  ready,
  output logic [IW-1:0] index,
  output logic          any_ready
);

  // Scan from the top so the lowest ready index is the last one written.
  always_comb begin
    index     = '0;
    any_ready = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        index     = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_integer.sv
// Age-ordered, compacting integer issue queue with CDB wakeup.
// Define ISSUEQ_CDB_BYPASS_EN to wake operands from the CDB in the dispatch cycle.
module issue_queue_integer
  import issue_queue_integer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispatch_en_integer,
  input  logic [4:0]        dispatch_opcode,
  input  logic [DATA_W-1:0] disp_rs1_data,
  input  logic [DATA_W-1:0] disp_rs2_data,
  input  logic              disp_rs1_valid,
  input  logic              disp_rs2_valid,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  input  logic              exec_ready,
  output logic              issue_valid,
  output logic [4:0]        issue_opcode,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic              issueque_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

`ifdef ISSUEQ_CDB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  iq_entry_t        q  [DEPTH];
  iq_entry_t        wk [DEPTH];
  iq_entry_t        nq [DEPTH];
  iq_entry_t        ent;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_after;
  logic [CW-1:0]    count_nxt;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    sel;
  logic             any;
  logic             fire;
  logic             accept;
  tag_t             ctag;
  data_t            cdata;

  assign ctag  = IQ_TAG_W'(cdb_tag);
  assign cdata = IQ_DATA_W'(cdb_data);

  // Only live entries with both operands present may issue.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = (CW'(i) < count) && both_rdy(q[i]);
    end
  end

  issue_select #(
    .N  (DEPTH),
    .IW (IW)
  ) u_select (
    .ready     (rdy),
    .index     (sel),
    .any_ready (any)
  );

  assign issueque_full  = (count == CW'(DEPTH));
  assign issue_valid    = any;
  assign issue_opcode   = q[sel].opcode;
  assign issue_rs1_data = DATA_W'(q[sel].rs1_data);
  assign issue_rs2_data = DATA_W'(q[sel].rs2_data);
  assign issue_rd_tag   = TAG_W'(q[sel].rd_tag);

  assign fire        = any & exec_ready;
  assign accept      = dispatch_en_integer & ~issueque_full;
  assign count_after = count - CW'(fire);

  // Build the incoming entry, optionally catching a same-cycle broadcast.
  always_comb begin
    ent          = '0;
    ent.opcode   = dispatch_opcode;
    ent.rs1_data = IQ_DATA_W'(disp_rs1_data);
    ent.rs1_tag  = IQ_TAG_W'(disp_rs1_tag);
    ent.rs1_rdy  = disp_rs1_valid;
    ent.rs2_data = IQ_DATA_W'(disp_rs2_data);
    ent.rs2_tag  = IQ_TAG_W'(disp_rs2_tag);
    ent.rs2_rdy  = disp_rs2_valid;
    ent.rd_tag   = IQ_TAG_W'(disp_rd_tag);
    if (BYPASS && cdb_valid) begin
      ent = wake(ent, ctag, cdata);
    end
  end

  // Wakeup, then close the issued slot, then append at the new tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk[i] = q[i];
      if (cdb_valid && CW'(i) < count) begin
        wk[i] = wake(q[i], ctag, cdata);
      end
      nq[i] = wk[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (fire && IW'(i) >= sel) begin
        nq[i] = wk[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && count_after == CW'(i)) begin
        nq[i] = ent;
      end
    end
  end

  // Flush empties the queue regardless of anything else this cycle.
  always_comb begin
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count_after + CW'(accept);
    end
  end

  // Occupancy is the only state that needs reset; it gates every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    q <= nq;
  end

endmodule

// File: tb/tb_issue_queue_integer.sv
// Scoreboard bench for issue_queue_integer: a queue-based model predicts
// every accepted issue and a separate monitor checks what the DUT presents.
module tb_issue_queue_integer;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

`ifdef ISSUEQ_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              dispatch_en_integer;
  logic [4:0]        dispatch_opcode;
  logic [DATA_W-1:0] disp_rs1_data;
  logic [DATA_W-1:0] disp_rs2_data;
  logic              disp_rs1_valid;
  logic              disp_rs2_valid;
  logic [TAG_W-1:0]  disp_rs1_tag;
  logic [TAG_W-1:0]  disp_rs2_tag;
  logic [TAG_W-1:0]  disp_rd_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              exec_ready;
  logic              issue_valid;
  logic [4:0]        issue_opcode;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic              issueque_full;

  issue_queue_integer #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dispatch_en_integer (dispatch_en_integer),
    .dispatch_opcode     (dispatch_opcode),
    .disp_rs1_data       (disp_rs1_data),
    .disp_rs2_data       (disp_rs2_data),
    .disp_rs1_valid      (disp_rs1_valid),
    .disp_rs2_valid      (disp_rs2_valid),
    .disp_rs1_tag        (disp_rs1_tag),
    .disp_rs2_tag        (disp_rs2_tag),
    .disp_rd_tag         (disp_rd_tag),
    .cdb_valid           (cdb_valid),
    .cdb_tag             (cdb_tag),
    .cdb_data            (cdb_data),
    .flush               (flush),
    .exec_ready          (exec_ready),
    .issue_valid         (issue_valid),
    .issue_opcode        (issue_opcode),
    .issue_rs1_data      (issue_rs1_data),
    .issue_rs2_data      (issue_rs2_data),
    .issue_rd_tag        (issue_rd_tag),
    .issueque_full       (issueque_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        opc;
    logic [DATA_W-1:0] d1;
    bit                v1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d2;
    bit                v2;
    logic [TAG_W-1:0]  t2;
    logic [TAG_W-1:0]  rd;
  } m_ent_t;

  typedef struct {
    logic [4:0]        opc;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [TAG_W-1:0]  rd;
  } exp_t;

  m_ent_t mq[$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     armed    = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluates the upcoming edge from stable inputs.
  always @(negedge clk) begin
    int     k;
    bit     was_full;
    m_ent_t e;
    exp_t   x;
    k = -1;
    foreach (mq[i]) if (k < 0 && mq[i].v1 && mq[i].v2) k = i;
    if (armed) begin
      check("issue_valid", 64'(issue_valid), 64'(k >= 0));
      check("full", 64'(issueque_full), 64'(mq.size() == DEPTH));
    end
    if (!rst_n) begin
      mq.delete();
      armed = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (k >= 0 && exec_ready) begin
        x.opc = mq[k].opc;
        x.d1  = mq[k].d1;
        x.d2  = mq[k].d2;
        x.rd  = mq[k].rd;
        exp_q.push_back(x);
      end
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].v1 && mq[i].t1 == cdb_tag) begin
            mq[i].v1 = 1'b1;
            mq[i].d1 = cdb_data;
          end
          if (!mq[i].v2 && mq[i].t2 == cdb_tag) begin
            mq[i].v2 = 1'b1;
            mq[i].d2 = cdb_data;
          end
        end
      end
      if (k >= 0 && exec_ready) mq.delete(k);
      if (dispatch_en_integer && !was_full) begin
        e.opc = dispatch_opcode;
        e.d1  = disp_rs1_data;
        e.v1  = disp_rs1_valid;
        e.t1  = disp_rs1_tag;
        e.d2  = disp_rs2_data;
        e.v2  = disp_rs2_valid;
        e.t2  = disp_rs2_tag;
        e.rd  = disp_rd_tag;
        if (BYPASS && cdb_valid) begin
          if (!e.v1 && e.t1 == cdb_tag) begin
            e.v1 = 1'b1;
            e.d1 = cdb_data;
          end
          if (!e.v2 && e.t2 == cdb_tag) begin
            e.v2 = 1'b1;
            e.d2 = cdb_data;
          end
        end
        mq.push_back(e);
      end
    end
  end

  // Monitor: every issue the DUT hands over must match the next prediction.
  always @(negedge clk) begin
    exp_t x;
    #1;
    if (armed && rst_n && !flush && issue_valid && exec_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 64'(issue_valid), 64'(0));
      end else begin
        x = exp_q.pop_front();
        check("issue_opcode", 64'(issue_opcode), 64'(x.opc));
        check("issue_rs1", 64'(issue_rs1_data), 64'(x.d1));
        check("issue_rs2", 64'(issue_rs2_data), 64'(x.d2));
        check("issue_rd", 64'(issue_rd_tag), 64'(x.rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dispatch_en_integer = 1'b0;
    cdb_valid           = 1'b0;
    flush               = 1'b0;
  endtask

  task automatic disp(input logic [4:0] opc,
                      input logic [DATA_W-1:0] d1, input logic v1,
                      input logic [TAG_W-1:0] t1,
                      input logic [DATA_W-1:0] d2, input logic v2,
                      input logic [TAG_W-1:0] t2,
                      input logic [TAG_W-1:0] rd);
    dispatch_en_integer = 1'b1;
    dispatch_opcode     = opc;
    disp_rs1_data       = d1;
    disp_rs1_valid      = v1;
    disp_rs1_tag        = t1;
    disp_rs2_data       = d2;
    disp_rs2_valid      = v2;
    disp_rs2_tag        = t2;
    disp_rd_tag         = rd;
  endtask

  task automatic bcast(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    exec_ready = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    dispatch_en_integer = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single ready instruction issues the cycle after dispatch.
    exec_ready = 1'b1;
    disp(5'b00000, 32'h11, 1'b1, 6'd1, 32'h22, 1'b1, 6'd2, 6'd3);
    step();
    step();
    step();

    // Fill with waiters on tag 5, overflow dispatch, then one broadcast.
    exec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(i + 1), 32'h0, 1'b0, 6'd5, 32'(100 + i), 1'b1, 6'd0, 6'(10 + i));
      step();
    end
    disp(5'h1f, 32'h1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 6'd63);
    step();
    exec_ready = 1'b1;
    bcast(6'd5, 32'hDEAD);
    step();
    for (int i = 0; i < 5; i++) step();

    // Younger ready entry bypasses older waiters; order is preserved.
    exec_ready = 1'b0;
    disp(5'd2, 32'h0, 1'b0, 6'd1, 32'h5, 1'b1, 6'd0, 6'd20); step();
    disp(5'd3, 32'h0, 1'b0, 6'd2, 32'h6, 1'b1, 6'd0, 6'd21); step();
    disp(5'd4, 32'h7, 1'b1, 6'd0, 32'h8, 1'b1, 6'd0, 6'd22); step();
    disp(5'd5, 32'h9, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0, 6'd23); step();
    exec_ready = 1'b1;
    step();
    step();
    bcast(6'd1, 32'hAAAA); step();
    bcast(6'd2, 32'hBBBB); step();
    for (int i = 0; i < 4; i++) step();

    // Broadcast in the dispatch cycle of a waiting operand.
    disp(5'd6, 32'h3, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7, 6'd30);
    bcast(6'd7, 32'hBEEF);
    step();
    step();
    step();
    bcast(6'd7, 32'hCAFE);
    step();
    step();
    step();

    // Flush with a concurrent dispatch empties the queue.
    exec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(5'd7, 32'h0, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 6'(40 + i));
      step();
    end
    disp(5'd8, 32'h1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 6'd50);
    flush = 1'b1;
    step();
    step();

    // Reset while two ready entries wait on a stalled unit.
    disp(5'd9, 32'h1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 6'd51); step();
    disp(5'd10, 32'h3, 1'b1, 6'd0, 32'h4, 1'b1, 6'd0, 6'd52); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      dispatch_en_integer = ($urandom_range(0, 99) < 60);
      dispatch_opcode     = 5'($urandom);
      disp_rs1_data       = $urandom;
      disp_rs2_data       = $urandom;
      disp_rs1_valid      = 1'($urandom_range(0, 1));
      disp_rs2_valid      = 1'($urandom_range(0, 1));
      disp_rs1_tag        = 6'($urandom_range(0, 7));
      disp_rs2_tag        = 6'($urandom_range(0, 7));
      disp_rd_tag         = 6'($urandom);
      cdb_valid           = ($urandom_range(0, 99) < 40);
      cdb_tag             = 6'($urandom_range(0, 7));
      cdb_data            = $urandom;
      flush               = ($urandom_range(0, 99) < 2);
      exec_ready          = ($urandom_range(0, 99) < 70);
      rst_n               = ($urandom_range(0, 199) != 0);
      step();
    end

    // Drain: wake every tag in use and let everything issue.
    rst_n = 1'b1;
    exec_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bcast(6'(t), 32'(t + 32'h1000));
      step();
    end
    for (int i = 0; i < 2 * DEPTH; i++) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
